// File: rtl/aes_spi_slave_pkg.sv
// Shared types and width helpers for the AES SPI responder.
// The state encoding and block/key widths live here so the bench and any wrapper agree on them.
package aes_spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        CORE = 2'd2,
        TX   = 2'd3
    } state_t;

    function automatic int blk_bits(input int nb);
        return 32 * nb;
    endfunction

    function automatic int key_bits(input int nk);
        return 32 * nk;
    endfunction

endpackage

// File: rtl/aes_spi_slave_if.sv
// Serial link between the Master and the unit-side responder.
// Master drives the select, data and qualifier; the responder returns the result bit and its valid.
interface aes_spi_slave_if;
    logic cs;
    logic Mosi;
    logic in_valid;
    logic Miso;
    logic out_valid;

    modport master (output cs, Mosi, in_valid, input Miso, out_valid);
    modport slave  (input cs, Mosi, in_valid, output Miso, out_valid);
endinterface

// File: rtl/aes_spi_slave_shift_reg.sv
// MSB-first shift register with parallel load, used for both the receive frame and the transmit block.
// Load has priority over shift; a new bit enters at the LSB.
module aes_spi_slave_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/aes_spi_slave.sv
// Unit-side SPI responder: collects message+key, starts the cipher core, returns the result block.
// state | meaning: IDLE wait for frame | RX shifting frame in | CORE core running | TX shifting result out
module aes_spi_slave
    import aes_spi_slave_pkg::*;
#(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    aes_spi_slave_if.slave           spi,
    output logic [blk_bits(nb)-1:0]  core_msg,
    output logic [key_bits(nk)-1:0]  core_key,
    output logic                     core_start,
    input  logic [blk_bits(nb)-1:0]  core_res,
    input  logic                     core_done,
    output logic                     busy
);

    localparam int BLK_BITS = blk_bits(nb);
    localparam int KEY_BITS = key_bits(nk);
    localparam int FRM_BITS = BLK_BITS + KEY_BITS;
    localparam int CNT_W    = $clog2(FRM_BITS + 1);
    localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FRM_BITS);
    localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(BLK_BITS - 1);

    if (nb != 4 || nr != nk + 6) begin : g_bad_cfg
        $error("aes_spi_slave: nb/nk/nr is not a valid AES configuration");
    end

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [FRM_BITS-1:0] rx_q;
    logic [BLK_BITS-1:0] tx_q;
    logic                rx_full;
    logic                tx_last;
    logic                accept;
    logic                tx_load;
    logic                tx_shift;
    logic                unused_tx_low;

    assign rx_full  = (cnt == FRM_LAST);
    assign tx_last  = (cnt == TX_LAST);
    assign accept   = spi.cs && spi.in_valid && ((state == IDLE) || ((state == RX) && !rx_full));
    assign tx_load  = (state == CORE) && spi.cs && core_done;
    assign tx_shift = (state == TX);

    // Message arrives first, so it ends up in the upper part of the frame register.
    assign core_msg = rx_q[FRM_BITS-1 -: BLK_BITS];
    assign core_key = rx_q[KEY_BITS-1:0];

    // Only the MSB of the transmit register ever leaves the block.
    assign unused_tx_low = ^tx_q[BLK_BITS-2:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (spi.cs && spi.in_valid) next_state = RX;
            RX: begin
                if (!spi.cs)      next_state = IDLE;
                else if (rx_full) next_state = CORE;
            end
            CORE: begin
                if (!spi.cs)        next_state = IDLE;
                else if (core_done) next_state = TX;
            end
            TX: if (!spi.cs || tx_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        core_start    = 1'b0;
        spi.out_valid = 1'b0;
        spi.Miso      = 1'b0;
        busy          = (state != IDLE);
        case (state)
            RX: core_start = rx_full && spi.cs;
            TX: begin
                spi.out_valid = 1'b1;
                spi.Miso      = tx_q[BLK_BITS-1];
            end
            default: ;
        endcase
    end

    // One counter serves both directions: frame bits in RX, result bits in TX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((next_state == IDLE) || (next_state == CORE)) begin
            cnt <= '0;
        end else if (accept || tx_shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    aes_spi_slave_shift_reg #(.WIDTH(FRM_BITS)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ('0),
        .shift    (accept),
        .din      (spi.Mosi),
        .q        (rx_q)
    );

    aes_spi_slave_shift_reg #(.WIDTH(BLK_BITS)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (core_res),
        .shift    (tx_shift),
        .din      (1'b0),
        .q        (tx_q)
    );

endmodule

// File: tb/tb_aes_spi_slave.sv
// Bench for aes_spi_slave: AES-128 and AES-256 instances, behavioural core, result scoreboard.
module tb_aes_spi_slave;

    localparam logic [127:0] MSG    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int           LAT    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_spi_slave_if bus4();
    aes_spi_slave_if bus8();

    logic [127:0] msg4, msg8, res4, res8;
    logic [127:0] key4;
    logic [255:0] key8;
    logic start4, start8, busy4, busy8;
    logic done4 = 1'b0;
    logic done8 = 1'b0;
    logic spur4 = 1'b0;

    aes_spi_slave #(.nk(4), .nb(4), .nr(10)) dut4 (
        .clk(clk), .rst(rst), .spi(bus4),
        .core_msg(msg4), .core_key(key4), .core_start(start4),
        .core_res(res4), .core_done(done4), .busy(busy4)
    );

    aes_spi_slave #(.nk(8), .nb(4), .nr(14)) dut8 (
        .clk(clk), .rst(rst), .spi(bus8),
        .core_msg(msg8), .core_key(key8), .core_start(start8),
        .core_res(res8), .core_done(done8), .busy(busy8)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Known-answer core: returns the FIPS-197 ciphertext for the vectors it knows.
    function automatic logic [127:0] core_model(input logic [127:0] m, input logic [255:0] k, input int klen);
        if (m == MSG && klen == 128 && k == KEY128) return CT128;
        if (m == MSG && klen == 256 && k == KEY256) return CT256;
        return m ^ k[127:0];
    endfunction

    int tmr4 = 0;
    int tmr8 = 0;
    always @(posedge clk) begin
        if (start4) begin
            tmr4 <= LAT;
            res4 <= core_model(msg4, {128'h0, key4}, 128);
        end else if (tmr4 != 0) begin
            tmr4 <= tmr4 - 1;
        end
        done4 <= (tmr4 == 1) || spur4;
        if (start8) begin
            tmr8 <= LAT;
            res8 <= core_model(msg8, key8, 256);
        end else if (tmr8 != 0) begin
            tmr8 <= tmr8 - 1;
        end
        done8 <= (tmr8 == 1);
    end

    logic [127:0] q4[$];
    logic [127:0] q8[$];
    logic [127:0] acc4, acc8;
    int nbit4 = 0, nbit8 = 0, part4 = 0, part8 = 0;

    always @(negedge clk) begin
        if (bus4.out_valid) begin
            acc4 = {acc4[126:0], bus4.Miso};
            nbit4++;
            if (nbit4 == 128) begin
                check_val("tx4_expected", q4.size() > 0, 1'b1);
                if (q4.size() > 0) check_val("miso4_block", acc4, q4.pop_front());
                nbit4 = 0;
            end
        end else begin
            check_val("miso4_idle", bus4.Miso, 1'b0);
            if (nbit4 != 0) begin
                part4++;
                nbit4 = 0;
            end
        end
        if (bus8.out_valid) begin
            acc8 = {acc8[126:0], bus8.Miso};
            nbit8++;
            if (nbit8 == 128) begin
                check_val("tx8_expected", q8.size() > 0, 1'b1);
                if (q8.size() > 0) check_val("miso8_block", acc8, q8.pop_front());
                nbit8 = 0;
            end
        end else begin
            check_val("miso8_idle", bus8.Miso, 1'b0);
            if (nbit8 != 0) begin
                part8++;
                nbit8 = 0;
            end
        end
    end

    task automatic drive(input int sel, input logic c, input logic v, input logic b);
        if (sel == 4) begin
            bus4.cs = c; bus4.in_valid = v; bus4.Mosi = b;
        end else begin
            bus8.cs = c; bus8.in_valid = v; bus8.Mosi = b;
        end
    endtask

    function automatic logic g_start(input int sel); return sel == 4 ? start4 : start8; endfunction
    function automatic logic g_busy(input int sel);  return sel == 4 ? busy4 : busy8; endfunction
    function automatic logic g_ov(input int sel);    return sel == 4 ? bus4.out_valid : bus8.out_valid; endfunction
    function automatic logic g_miso(input int sel);  return sel == 4 ? bus4.Miso : bus8.Miso; endfunction
    function automatic logic g_done(input int sel);  return sel == 4 ? done4 : done8; endfunction
    function automatic logic [127:0] g_msg(input int sel); return sel == 4 ? msg4 : msg8; endfunction
    function automatic logic [255:0] g_key(input int sel); return sel == 4 ? {128'h0, key4} : key8; endfunction

    // abort_kind: 1 = drop cs before bit abort_at, 2 = assert reset before bit abort_at
    task automatic send_frame(input int sel, input logic [127:0] m, input logic [255:0] k,
                              input int stall_at, input int abort_at, input int abort_kind);
        int klen;
        int frm;
        int t0;
        logic b;
        klen = (sel == 4) ? 128 : 256;
        frm  = 128 + klen;
        t0   = cyc;
        drive(sel, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < frm; i++) begin
            if (i == stall_at) begin
                drive(sel, 1'b1, 1'b0, 1'b0);
                repeat (5) @(negedge clk);
            end
            if (i == abort_at && abort_kind == 1) begin
                drive(sel, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                check_val("abort_busy", g_busy(sel), 1'b0);
                check_val("abort_nostart", g_start(sel), 1'b0);
                return;
            end
            if (i == abort_at && abort_kind == 2) begin
                drive(sel, 1'b0, 1'b0, 1'b0);
                rst = 1'b1;
                #1;
                check_val("rst_busy", g_busy(sel), 1'b0);
                check_val("rst_start", g_start(sel), 1'b0);
                check_val("rst_ov", g_ov(sel), 1'b0);
                check_val("rst_miso", g_miso(sel), 1'b0);
                check_val("rst_msg", g_msg(sel), 128'h0);
                check_val("rst_key", g_key(sel), 256'h0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            b = (i < 128) ? m[127-i] : k[klen-1-(i-128)];
            drive(sel, 1'b1, 1'b1, b);
            if (i == 0) t0 = cyc;
            @(negedge clk);
            if (i == frm - 2) check_val("start_early", g_start(sel), 1'b0);
        end
        drive(sel, 1'b1, 1'b0, 1'b0);
        check_val("start_pulse", g_start(sel), 1'b1);
        check_val("start_lat", cyc - t0, frm + ((stall_at >= 0) ? 5 : 0));
        check_val("core_msg", g_msg(sel), m);
        check_val("core_key", g_key(sel), k);
        @(negedge clk);
        check_val("start_once", g_start(sel), 1'b0);
        check_val("busy_core", g_busy(sel), 1'b1);
    endtask

    task automatic finish_tx(input int sel, input int tx_abort_at);
        int k;
        k = 0;
        while (!g_done(sel) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_val("done_seen", g_done(sel), 1'b1);
        check_val("ov_before", g_ov(sel), 1'b0);
        @(negedge clk);
        check_val("ov_first", g_ov(sel), 1'b1);
        if (tx_abort_at >= 0) begin
            repeat (tx_abort_at) @(negedge clk);
            drive(sel, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check_val("txabort_ov", g_ov(sel), 1'b0);
            check_val("txabort_miso", g_miso(sel), 1'b0);
            check_val("txabort_busy", g_busy(sel), 1'b0);
            spur4 = 1'b1;
            @(negedge clk);
            spur4 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                check_val("spur_busy", g_busy(sel), 1'b0);
                check_val("spur_ov", g_ov(sel), 1'b0);
            end
        end else begin
            k = 0;
            while (g_ov(sel) && k < 200) begin
                @(negedge clk);
                k++;
            end
            check_val("tx_len", k, 128);
            check_val("tx_end_busy", g_busy(sel), 1'b0);
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        drive(4, 1'b0, 1'b0, 1'b0);
        drive(8, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("reset_busy4", busy4, 1'b0);
        check_val("reset_ov4", bus4.out_valid, 1'b0);
        check_val("reset_start4", start4, 1'b0);
        check_val("reset_msg4", msg4, 128'h0);
        check_val("reset_busy8", busy8, 1'b0);
        check_val("reset_key8", key8, 256'h0);

        // reset in the middle of a frame, then a normal frame
        send_frame(4, MSG, KEY128, -1, 40, 2);
        send_frame(4, MSG, KEY128, -1, -1, 0);
        q4.push_back(CT128);
        finish_tx(4, -1);

        // five-cycle in_valid gap at bit 100
        send_frame(4, MSG, KEY128, 100, -1, 0);
        q4.push_back(CT128);
        finish_tx(4, -1);

        // cs dropped at bit 200, then a fresh frame
        send_frame(4, MSG, KEY128, -1, 200, 1);
        send_frame(4, MSG, KEY128, -1, -1, 0);
        q4.push_back(CT128);
        finish_tx(4, -1);

        // cs dropped during transmit bit 60, then a stray core_done while idle
        send_frame(4, MSG, KEY128, -1, -1, 0);
        finish_tx(4, 60);

        // AES-256 frame on the nk=8 instance
        send_frame(8, MSG, KEY256, -1, -1, 0);
        q8.push_back(CT256);
        finish_tx(8, -1);

        repeat (3) @(negedge clk);
        check_val("q4_drained", q4.size(), 0);
        check_val("q8_drained", q8.size(), 0);
        check_val("partial4", part4, 1);
        check_val("partial8", part8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
